// File: rtl/fifo_chk_pkg.sv
// Shared types and helpers for the FIFO drain checker: FSM states,
// throttle mode encodings and the throttle pattern decode.
package fifo_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } chk_state_e;

    localparam logic [1:0] THR_ALL    = 2'd0;
    localparam logic [1:0] THR_ALT    = 2'd1;
    localparam logic [1:0] THR_BURST4 = 2'd2;
    localparam logic [1:0] THR_ONE8   = 2'd3;

    // Pop permission for a given mode and 3-bit throttle phase.
    function automatic logic throttle_allow(input logic [1:0] mode, input logic [2:0] cnt);
        logic allow;
        case (mode)
            THR_ALL:    allow = 1'b1;
            THR_ALT:    allow = ~cnt[0];
            THR_BURST4: allow = ~cnt[2];
            default:    allow = (cnt == 3'd0);
        endcase
        return allow;
    endfunction

endpackage

// File: rtl/fifo_drain_checker_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fifo_drain_checker.sv
// Read-side self-test for a fallthrough FIFO: pops under a throttle pattern,
// checks an incrementing sequence, counts words/errors and captures the first mismatch.
//
//   state  | meaning
//   IDLE   | not popping; waiting for enable
//   RUN    | popping whenever the throttle allows and the FIFO is non-empty
//   HALTED | stopped after a mismatch (HALT_ON_ERR=1); left only via clear or reset
module fifo_drain_checker
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int FIRST_VALUE = 1,
    parameter int HALT_ON_ERR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [1:0]           throttle_mode,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [CNT_WIDTH-1:0] words_read,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 error,
    output logic [WIDTH-1:0]     first_err_data,
    output logic [WIDTH-1:0]     first_err_expected,
    output logic                 halted
);

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [2:0]       thr_cnt;
    logic [WIDTH-1:0] expected;
    logic             mismatch;

    assign mismatch   = (fifo_dout != expected);
    assign fifo_rd_en = (state_q == RUN) & ~fifo_empty & throttle_allow(throttle_mode, thr_cnt);
    assign halted     = (state_q == HALTED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (fifo_rd_en && mismatch && (HALT_ON_ERR != 0)) state_d = HALTED;
                else if (!enable)                                 state_d = IDLE;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q            <= IDLE;
            thr_cnt            <= '0;
            expected           <= WIDTH'(FIRST_VALUE);
            error              <= 1'b0;
            first_err_data     <= '0;
            first_err_expected <= '0;
        end else if (clear) begin
            // Clear discards any pop in this cycle; only HALTED changes state.
            state_q            <= (state_q == HALTED) ? IDLE : state_q;
            thr_cnt            <= '0;
            expected           <= WIDTH'(FIRST_VALUE);
            error              <= 1'b0;
            first_err_data     <= '0;
            first_err_expected <= '0;
        end else begin
            state_q <= state_d;
            thr_cnt <= ((state_q == RUN) && (state_d == RUN)) ? thr_cnt + 3'd1 : 3'd0;
            if (fifo_rd_en) begin
                // Resync on mismatch so a single gap is counted once.
                expected <= mismatch ? fifo_dout + WIDTH'(1) : expected + WIDTH'(1);
                if (mismatch && !error) begin
                    error              <= 1'b1;
                    first_err_data     <= fifo_dout;
                    first_err_expected <= expected;
                end
            end
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_words_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (fifo_rd_en),
        .q     (words_read)
    );

    sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (fifo_rd_en & mismatch),
        .q     (err_count)
    );

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Randomized bench: two checkers (HALT_ON_ERR 0 and 1) each drain their own
// modelled depth-8 fallthrough FIFO and are compared against a reference model.
module tb_fifo_drain_checker;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 8;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int DMOD  = 1 << W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          enable;
    logic          clear;
    logic [1:0]    throttle_mode;
    logic [W-1:0]  dout   [2];
    logic          empty  [2];
    logic          rd_en  [2];
    logic [CW-1:0] words  [2];
    logic [CW-1:0] errs   [2];
    logic          error  [2];
    logic [W-1:0]  fed    [2];
    logic [W-1:0]  fee    [2];
    logic          halted [2];

    fifo_drain_checker #(.WIDTH(W), .CNT_WIDTH(CW), .FIRST_VALUE(1), .HALT_ON_ERR(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .throttle_mode(throttle_mode),
        .fifo_dout(dout[0]), .fifo_empty(empty[0]), .fifo_rd_en(rd_en[0]),
        .words_read(words[0]), .err_count(errs[0]), .error(error[0]),
        .first_err_data(fed[0]), .first_err_expected(fee[0]), .halted(halted[0])
    );

    fifo_drain_checker #(.WIDTH(W), .CNT_WIDTH(CW), .FIRST_VALUE(1), .HALT_ON_ERR(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .throttle_mode(throttle_mode),
        .fifo_dout(dout[1]), .fifo_empty(empty[1]), .fifo_rd_en(rd_en[1]),
        .words_read(words[1]), .err_count(errs[1]), .error(error[1]),
        .first_err_data(fed[1]), .first_err_expected(fee[1]), .halted(halted[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", tag, idx, $time, got, exp);
        end
    endtask

    // FIFO contents per instance
    int fmem [2][DEPTH];
    int fcnt [2];
    int prod [2];

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int m_st [2];
    int m_ph [2];
    int m_exp [2];
    int m_words [2];
    int m_errs [2];
    int m_err [2];
    int m_fd [2];
    int m_fe [2];
    bit m_rd [2];

    function automatic bit allow(input int mode, input int ph);
        case (mode)
            0:       return 1'b1;
            1:       return (ph % 2) == 0;
            2:       return ph < 4;
            default: return ph == 0;
        endcase
    endfunction

    task automatic fifo_pop(input int i);
        for (int k = 0; k < DEPTH - 1; k++) fmem[i][k] = fmem[i][k+1];
        fcnt[i]--;
    endtask

    task automatic clear_model(input int i);
        m_ph[i] = 0; m_exp[i] = 1; m_words[i] = 0; m_errs[i] = 0;
        m_err[i] = 0; m_fd[i] = 0; m_fe[i] = 0;
    endtask

    // Apply one clock edge to the model, using the inputs that were stable before it.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit pop;
            bit mis;
            int head;
            int ns;
            pop  = m_rd[i];
            head = int'(dout[i]);
            mis  = (head != m_exp[i]);
            if (!reset) begin
                clear_model(i);
                m_st[i] = 0;
                fcnt[i] = 0;
                prod[i] = 1;
            end else if (clear) begin
                if (pop) fifo_pop(i);
                clear_model(i);
                if (m_st[i] == 2) m_st[i] = 0;
            end else begin
                if (pop) begin
                    fifo_pop(i);
                    if (m_words[i] < CMAX) m_words[i]++;
                    if (!mis) begin
                        m_exp[i] = (m_exp[i] + 1) % DMOD;
                    end else begin
                        if (m_errs[i] < CMAX) m_errs[i]++;
                        if (!m_err[i]) begin
                            m_err[i] = 1; m_fd[i] = head; m_fe[i] = m_exp[i];
                        end
                        m_exp[i] = (head + 1) % DMOD;
                    end
                end
                ns = m_st[i];
                if (m_st[i] == 0 && enable) ns = 1;
                if (m_st[i] == 1) begin
                    if (pop && mis && i == 1) ns = 2;
                    else if (!enable)         ns = 0;
                end
                m_ph[i] = (m_st[i] == 1 && ns == 1) ? (m_ph[i] + 1) % 8 : 0;
                m_st[i] = ns;
            end
        end
    endtask

    task automatic cycle(input int mode, input int push_pct, input int err_pct, input bit force_rst);
        @(posedge clk);
        #1;
        model_edge();
        reset         = force_rst ? 1'b0 : ($urandom_range(0, 199) != 0);
        clear         = ($urandom_range(0, 99) == 0);
        enable        = ($urandom_range(0, 19) != 0);
        throttle_mode = 2'(mode);
        for (int i = 0; i < 2; i++) begin
            if (fcnt[i] < DEPTH && $urandom_range(0, 99) < push_pct) begin
                int val;
                val = prod[i];
                if ($urandom_range(0, 99) < err_pct) val = (val + 2 + $urandom_range(0, 5)) % DMOD;
                fmem[i][fcnt[i]] = val;
                fcnt[i]++;
                prod[i] = (val + 1) % DMOD;
            end
            empty[i] = (fcnt[i] == 0);
            dout[i]  = (fcnt[i] == 0) ? W'(8'hA5) : W'(fmem[i][0]);
            m_rd[i]  = (m_st[i] == 1) && (fcnt[i] > 0) && allow(mode, m_ph[i]);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rd_en",          i, 32'(rd_en[i]),  32'(m_rd[i]));
            check("words_read",     i, 32'(words[i]),  32'(m_words[i]));
            check("err_count",      i, 32'(errs[i]),   32'(m_errs[i]));
            check("error",          i, 32'(error[i]),  32'(m_err[i]));
            check("first_err_data", i, 32'(fed[i]),    32'(m_fd[i]));
            check("first_err_exp",  i, 32'(fee[i]),    32'(m_fe[i]));
            check("halted",         i, 32'(halted[i]), 32'(m_st[i] == 2));
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0; throttle_mode = 2'd0;
        for (int i = 0; i < 2; i++) begin
            dout[i] = '0; empty[i] = 1'b1; fcnt[i] = 0; prod[i] = 1;
            m_st[i] = 0; m_rd[i] = 1'b0;
            clear_model(i);
        end
        for (int seg = 0; seg < 30; seg++) begin
            int mode;
            int push_pct;
            int err_pct;
            mode     = (seg < 4) ? seg : int'($urandom_range(0, 3));
            push_pct = (seg % 3 == 0) ? 100 : ((seg % 3 == 1) ? 33 : int'($urandom_range(10, 90)));
            err_pct  = (seg < 4) ? 0 : ((seg % 2 == 0) ? 0 : 4);
            for (int c = 0; c < 60; c++) cycle(mode, push_pct, err_pct, (c < 2) && (seg % 8 == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
